store_write_buffer: RTL and testbench

- Posted-store buffer between the processor's load/store path and the word-addressed data memory.
- Accepts stores in one cycle and queues up to DEPTH entries in FIFO order.
- Drains one entry per cycle into the memory write port whenever that port is free.
- Forwards the youngest matching buffered store to loads, so program order is preserved without waiting for the drain.

---
 rtl/store_write_buffer_pkg.sv | 25 ++
 rtl/store_write_buffer_fifo.sv | 83 ++++++++
 rtl/store_write_buffer.sv | 88 ++++++++
 tb/tb_store_write_buffer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the posted-store write buffer.
//   SWB_WIDTH / SWB_ADDR_BITS / SWB_DEPTH : default data, address and depth sizes
//   swb_count_w() : width of an occupancy counter spanning 0..depth
//   swb_ptr_w()   : width of a ring pointer indexing depth entries
package store_write_buffer_pkg;

  localparam int unsigned SWB_WIDTH     = 32;
  localparam int unsigned SWB_ADDR_BITS = 32;
  localparam int unsigned SWB_DEPTH     = 4;

  // Buffer entry layout with the default field widths.
  typedef struct packed {
    logic [SWB_ADDR_BITS-1:0] addr;
    logic [SWB_WIDTH-1:0]     data;
  } swb_entry_t;

  function automatic int unsigned swb_count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned swb_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_write_buffer_fifo.sv
// Ring-buffer storage for the store write buffer.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i/push_addr_i/push_data_i : enqueue at tail (ignored when full)
//   pop_i               : dequeue at head (ignored when empty)
//   head_addr_o/head_data_o/head_ptr_o : oldest entry and its slot index
//   full_o, empty_o, count_o : registered occupancy
//   ent_addr_o/ent_data_o/ent_valid_o : every slot, for load forwarding
module swb_fifo
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = SWB_WIDTH,
  parameter int unsigned ADDR_BITS = SWB_ADDR_BITS,
  parameter int unsigned DEPTH     = SWB_DEPTH
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                push_i,
  input  logic [ADDR_BITS-1:0]                push_addr_i,
  input  logic [WIDTH-1:0]                    push_data_i,
  input  logic                                pop_i,
  output logic [ADDR_BITS-1:0]                head_addr_o,
  output logic [WIDTH-1:0]                    head_data_o,
  output logic [swb_ptr_w(DEPTH)-1:0]         head_ptr_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [swb_count_w(DEPTH)-1:0]       count_o,
  output logic [DEPTH-1:0][ADDR_BITS-1:0]     ent_addr_o,
  output logic [DEPTH-1:0][WIDTH-1:0]         ent_data_o,
  output logic [DEPTH-1:0]                    ent_valid_o
);

  localparam int unsigned PW = swb_ptr_w(DEPTH);
  localparam int unsigned CW = swb_count_w(DEPTH);

  logic [DEPTH-1:0][ADDR_BITS-1:0] addr_q;
  logic [DEPTH-1:0][WIDTH-1:0]     data_q;
  logic [DEPTH-1:0]                valid_q;
  logic [PW-1:0]                   head_q, tail_q;
  logic [CW-1:0]                   count_q, count_d;
  logic                            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        addr_q[tail_q]  <= push_addr_i;
        data_q[tail_q]  <= push_data_i;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign head_ptr_o  = head_q;
  assign count_o     = count_q;
  assign ent_addr_o  = addr_q;
  assign ent_data_o  = data_q;
  assign ent_valid_o = valid_q;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer between the load/store path and word-addressed memory.
//   CLK, RST        : clock, synchronous active-high reset
//   CPU_A/CPU_WD    : load/store address, store data
//   CPU_WE/CPU_RE   : store / load request
//   CPU_RD          : load data (youngest buffered match, else MEM_RD)
//   STALL           : store refused because the buffer is full
//   MEM_A/MEM_WD/MEM_WE : memory port, drained one entry per cycle
//   MEM_RD          : memory read data
//   MEM_WBLOCK      : memory write port busy with another master
//   EMPTY, COUNT    : registered occupancy
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = SWB_WIDTH,
  parameter int unsigned ADDR_BITS = SWB_ADDR_BITS,
  parameter int unsigned DEPTH     = SWB_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ADDR_BITS-1:0]          CPU_A,
  input  logic [WIDTH-1:0]              CPU_WD,
  input  logic                          CPU_WE,
  input  logic                          CPU_RE,
  output logic [WIDTH-1:0]              CPU_RD,
  output logic                          STALL,
  output logic [ADDR_BITS-1:0]          MEM_A,
  output logic [WIDTH-1:0]              MEM_WD,
  output logic                          MEM_WE,
  input  logic [WIDTH-1:0]              MEM_RD,
  input  logic                          MEM_WBLOCK,
  output logic                          EMPTY,
  output logic [swb_count_w(DEPTH)-1:0] COUNT
);

  localparam int unsigned PW = swb_ptr_w(DEPTH);

  logic [ADDR_BITS-1:0]            head_addr;
  logic [WIDTH-1:0]                head_data;
  logic [PW-1:0]                   head_ptr;
  logic                            full, empty, drain;
  logic [DEPTH-1:0][ADDR_BITS-1:0] ent_addr;
  logic [DEPTH-1:0][WIDTH-1:0]     ent_data;
  logic [DEPTH-1:0]                ent_valid;
  logic [PW-1:0]                   idx;

  swb_fifo #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (CPU_WE),
    .push_addr_i (CPU_A),
    .push_data_i (CPU_WD),
    .pop_i       (drain),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_ptr_o  (head_ptr),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (COUNT),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data),
    .ent_valid_o (ent_valid)
  );

  // A load owns the address lines, except when it coincides with a store:
  // that cycle is treated as a store only, so draining stays allowed.
  assign drain  = ~RST & ~empty & ~MEM_WBLOCK & (~CPU_RE | CPU_WE);
  assign STALL  = ~RST & CPU_WE & full;
  assign MEM_WE = drain;
  assign MEM_A  = drain ? head_addr : CPU_A;
  assign MEM_WD = head_data;
  assign EMPTY  = empty;

  // Walk oldest to youngest; the last hit overwrites earlier ones, which is
  // the same as searching backwards from tail-1 and stopping at the first.
  always_comb begin
    CPU_RD = MEM_RD;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (ent_valid[idx] && (ent_addr[idx] == CPU_A)) CPU_RD = ent_data[idx];
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  logic        CLK = 1'b0;
  logic        RST, CPU_WE, CPU_RE, MEM_WBLOCK;
  logic [31:0] CPU_A, CPU_WD, MEM_RD;
  logic [31:0] CPU_RD, MEM_A, MEM_WD;
  logic        STALL, MEM_WE, EMPTY;
  logic [2:0]  COUNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  store_write_buffer #(
    .WIDTH     (32),
    .ADDR_BITS (32),
    .DEPTH     (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CPU_A      (CPU_A),
    .CPU_WD     (CPU_WD),
    .CPU_WE     (CPU_WE),
    .CPU_RE     (CPU_RE),
    .CPU_RD     (CPU_RD),
    .STALL      (STALL),
    .MEM_A      (MEM_A),
    .MEM_WD     (MEM_WD),
    .MEM_WE     (MEM_WE),
    .MEM_RD     (MEM_RD),
    .MEM_WBLOCK (MEM_WBLOCK),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT)
  );

  typedef struct {
    logic        we, re;
    logic [31:0] a, wd;
    logic        blk;
    logic [31:0] mrd;
    logic        stall, mwe;
    logic [31:0] ma, mwd, rd;
    logic [2:0]  cnt;
    logic        empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic re, logic [31:0] a, logic [31:0] wd,
                              logic blk, logic [31:0] mrd, logic stall, logic mwe,
                              logic [31:0] ma, logic [31:0] mwd, logic [31:0] rd,
                              logic [2:0] cnt, logic empty);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd; v.blk = blk; v.mrd = mrd;
    v.stall = stall; v.mwe = mwe; v.ma = ma; v.mwd = mwd; v.rd = rd;
    v.cnt = cnt; v.empty = empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic blk, input logic [31:0] mrd);
    @(posedge CLK);
    #1;
    RST = rst; CPU_WE = we; CPU_RE = re; CPU_A = a; CPU_WD = wd;
    MEM_WBLOCK = blk; MEM_RD = mrd;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] D = 32'hDEAD;
  localparam logic [31:0] M = 32'h1234;

  initial begin
    RST = 1'b1; CPU_WE = 1'b0; CPU_RE = 1'b0; CPU_A = '0; CPU_WD = '0;
    MEM_WBLOCK = 1'b0; MEM_RD = D;

    // Power-on reset, with a store request held during reset.
    step(1, 1, 0, 32'd9, 32'h99, 0, D);
    step(1, 1, 0, 32'd9, 32'h99, 0, D);
    chk("rst_mem_we", 32'(MEM_WE), 32'd0);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_empty", 32'(EMPTY), 32'd1);

    // Fill 3 entries while blocked, then reset mid-operation.
    step(0, 1, 0, 32'd1, 32'h1, 1, D);
    step(0, 1, 0, 32'd2, 32'h2, 1, D);
    step(0, 1, 0, 32'd3, 32'h3, 1, D);
    step(0, 0, 0, 32'd0, 32'h0, 1, D);
    chk("fill3_count", 32'(COUNT), 32'd3);
    step(1, 1, 0, 32'd9, 32'h9, 0, D);
    chk("midrst_mem_we", 32'(MEM_WE), 32'd0);
    chk("midrst_stall", 32'(STALL), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'd0, 32'h0, 0, D);
      chk($sformatf("postrst_count_%0d", i), 32'(COUNT), 32'd0);
      chk($sformatf("postrst_empty_%0d", i), 32'(EMPTY), 32'd1);
      chk($sformatf("postrst_no_write_%0d", i), 32'(MEM_WE), 32'd0);
    end

    //              we re a      wd          blk mrd stall mwe ma     mwd         rd          cnt empty
    // single store
    vecs.push_back(mk(1, 0, 32'd5, 32'hAAAA, 0, D, 0, 0, 32'd5, 32'h0,    D,          3'd0, 1));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd5, 32'hAAAA, D,          3'd1, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 0, 32'd0, 32'h0,    D,          3'd0, 1));
    // youngest match forwarded
    vecs.push_back(mk(1, 0, 32'd7, 32'h11,   1, D, 0, 0, 32'd7, 32'h0,    D,          3'd0, 1));
    vecs.push_back(mk(1, 0, 32'd7, 32'h22,   1, D, 0, 0, 32'd7, 32'h0,    32'h11,     3'd1, 0));
    vecs.push_back(mk(0, 1, 32'd7, 32'h0,    1, D, 0, 0, 32'd7, 32'h0,    32'h22,     3'd2, 0));
    vecs.push_back(mk(0, 1, 32'd7, 32'h0,    0, D, 0, 0, 32'd7, 32'h0,    32'h22,     3'd2, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd7, 32'h11,   D,          3'd2, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd7, 32'h22,   D,          3'd1, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 0, 32'd0, 32'h0,    D,          3'd0, 1));
    // full / stall
    vecs.push_back(mk(1, 0, 32'd1, 32'h101,  1, D, 0, 0, 32'd1, 32'h0,    D,          3'd0, 1));
    vecs.push_back(mk(1, 0, 32'd2, 32'h102,  1, D, 0, 0, 32'd2, 32'h0,    D,          3'd1, 0));
    vecs.push_back(mk(1, 0, 32'd3, 32'h103,  1, D, 0, 0, 32'd3, 32'h0,    D,          3'd2, 0));
    vecs.push_back(mk(1, 0, 32'd4, 32'h104,  1, D, 0, 0, 32'd4, 32'h0,    D,          3'd3, 0));
    vecs.push_back(mk(1, 0, 32'd5, 32'h105,  1, D, 1, 0, 32'd5, 32'h0,    D,          3'd4, 0));
    vecs.push_back(mk(1, 0, 32'd5, 32'h105,  0, D, 1, 1, 32'd1, 32'h101,  D,          3'd4, 0));
    vecs.push_back(mk(1, 0, 32'd5, 32'h105,  0, D, 0, 1, 32'd2, 32'h102,  D,          3'd3, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd3, 32'h103,  D,          3'd3, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd4, 32'h104,  D,          3'd2, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd5, 32'h105,  D,          3'd1, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 0, 32'd0, 32'h0,    D,          3'd0, 1));
    // loads block the drain
    vecs.push_back(mk(1, 0, 32'd8, 32'h81,   1, D, 0, 0, 32'd8, 32'h0,    D,          3'd0, 1));
    vecs.push_back(mk(1, 0, 32'd6, 32'h61,   1, D, 0, 0, 32'd6, 32'h0,    D,          3'd1, 0));
    vecs.push_back(mk(0, 1, 32'd9, 32'h0,    0, M, 0, 0, 32'd9, 32'h0,    M,          3'd2, 0));
    vecs.push_back(mk(0, 1, 32'd9, 32'h0,    0, M, 0, 0, 32'd9, 32'h0,    M,          3'd2, 0));
    vecs.push_back(mk(0, 1, 32'd9, 32'h0,    0, M, 0, 0, 32'd9, 32'h0,    M,          3'd2, 0));
    // simultaneous push and pop
    vecs.push_back(mk(1, 0, 32'd3, 32'h33,   0, M, 0, 1, 32'd8, 32'h81,   M,          3'd2, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd6, 32'h61,   D,          3'd2, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd3, 32'h33,   D,          3'd1, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 0, 32'd0, 32'h0,    D,          3'd0, 1));
    // store and load together: treated as a store, drain still allowed
    vecs.push_back(mk(1, 1, 32'd4, 32'h44,   0, D, 0, 0, 32'd4, 32'h0,    D,          3'd0, 1));
    vecs.push_back(mk(1, 1, 32'd4, 32'h45,   0, D, 0, 1, 32'd4, 32'h44,   32'h44,     3'd1, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 1, 32'd4, 32'h45,   D,          3'd1, 0));
    vecs.push_back(mk(0, 0, 32'd0, 32'h0,    0, D, 0, 0, 32'd0, 32'h0,    D,          3'd0, 1));

    foreach (vecs[i]) begin
      step(0, vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].blk, vecs[i].mrd);
      chk($sformatf("v%0d_stall", i), 32'(STALL), 32'(vecs[i].stall));
      chk($sformatf("v%0d_mem_we", i), 32'(MEM_WE), 32'(vecs[i].mwe));
      chk($sformatf("v%0d_mem_a", i), MEM_A, vecs[i].ma);
      if (vecs[i].mwe) chk($sformatf("v%0d_mem_wd", i), MEM_WD, vecs[i].mwd);
      chk($sformatf("v%0d_cpu_rd", i), CPU_RD, vecs[i].rd);
      chk($sformatf("v%0d_count", i), 32'(COUNT), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(EMPTY), 32'(vecs[i].empty));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
